// File: rtl/jtframe_ba0_arb_pkg.sv
// Shared types and constants for the SDRAM bank 0 arbiter.
package jtframe_ba0_arb_pkg;

   // Arbiter phases: idle, command outstanding, waiting for completion
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

   // Byte write mask: a set bit keeps that byte untouched
   localparam int unsigned            MASK_W    = 2;
   localparam logic [MASK_W-1:0]      MASK_NONE = 2'b00;

endpackage

// File: rtl/jtframe_ba0_arb_pick.sv
// Combinational N-way picker: first active request found scanning upward
// from 'start' (wrapping), returned both one-hot and as an index.
module jtframe_ba0_arb_pick
   import jtframe_ba0_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned NW = $clog2(N)
)(
   input  logic [N-1:0]  req,
   input  logic [NW-1:0] start,
   output logic [N-1:0]  onehot,
   output logic [NW-1:0] idx
);

   localparam int unsigned SW = NW + 1;

   logic [SW-1:0] pos;
   logic          found;

   // Rotating scan; start = 0 gives fixed priority with requester 0 first
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      pos    = '0;
      for (int k = 0; k < N; k++) begin
         pos = SW'(start) + SW'(k);
         if (pos >= SW'(N)) pos = pos - SW'(N);
         if (!found && req[NW'(pos)]) begin
            found               = 1'b1;
            onehot[NW'(pos)]    = 1'b1;
            idx                 = NW'(pos);
         end
      end
   end

endmodule

// File: rtl/jtframe_ba0_arbiter.sv
// SDRAM bank 0 arbiter: shares the single R/W bank between N requesters,
// latching the winner's command and routing board strobes back to it.
// Define JTFRAME_BA0_ARB_RR_EN for round-robin; default is fixed priority.
module jtframe_ba0_arbiter
   import jtframe_ba0_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned AW = 23,
   parameter int unsigned DW = 16
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_rd,
   input  logic [N-1:0]    req_wr,
   input  logic [N*AW-1:0] req_addr,
   input  logic [N*DW-1:0] req_din,
   input  logic [N*2-1:0]  req_din_m,
   output logic [N-1:0]    req_ack,
   output logic [N-1:0]    req_dst,
   output logic [N-1:0]    req_dok,
   output logic [N-1:0]    req_rdy,
   output logic [N-1:0]    gnt,
   output logic [AW-1:0]   ba_addr,
   output logic            ba_rd,
   output logic            ba_wr,
   output logic [DW-1:0]   ba_din,
   output logic [1:0]      ba_din_m,
   input  logic            ba_ack,
   input  logic            ba_dst,
   input  logic            ba_dok,
   input  logic            ba_rdy
);

   localparam int unsigned NW = $clog2(N);

   arb_state_t          state, state_nx;
   logic [N-1:0]        gnt_nx;
   logic                rd_nx, wr_nx;
   logic [AW-1:0]       addr_nx;
   logic [DW-1:0]       din_nx;
   logic [MASK_W-1:0]   din_m_nx;

   logic [N-1:0]        req_any;
   logic                any_req;
   logic [N-1:0]        pick_onehot;
   logic [NW-1:0]       pick_idx;
   logic [NW-1:0]       pick_start;

   assign req_any = req_rd | req_wr;
   assign any_req = |req_any;

   jtframe_ba0_arb_pick #(.N(N), .NW(NW)) u_pick (
      .req    (req_any),
      .start  (pick_start),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

`ifdef JTFRAME_BA0_ARB_RR_EN
   logic [NW-1:0] rr_ptr;

   // Search start moves just past the winner on every grant
   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (state == IDLE && any_req)
         rr_ptr <= (pick_idx == NW'(N-1)) ? '0 : pick_idx + NW'(1);
   end

   assign pick_start = rr_ptr;
`else
   assign pick_start = '0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state: one command per grant, completion returns to IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = REQ;
         REQ:     if (ba_ack)  state_nx = ba_rdy ? IDLE : WAIT;
         WAIT:    if (ba_rdy)  state_nx = IDLE;
         default:              state_nx = IDLE;
      endcase
   end

   // Next values for the registered grant and board command
   always_comb begin
      gnt_nx   = gnt;
      rd_nx    = ba_rd;
      wr_nx    = ba_wr;
      addr_nx  = ba_addr;
      din_nx   = ba_din;
      din_m_nx = ba_din_m;
      case (state)
         IDLE: begin
            if (any_req) begin
               gnt_nx   = pick_onehot;
               wr_nx    = |(pick_onehot & req_wr);   // write wins over read
               rd_nx    = ~wr_nx;
               addr_nx  = req_addr [32'(pick_idx)*AW     +: AW];
               din_nx   = req_din  [32'(pick_idx)*DW     +: DW];
               din_m_nx = req_din_m[32'(pick_idx)*MASK_W +: MASK_W];
            end
         end
         REQ: begin
            if (ba_ack) begin
               rd_nx = 1'b0;
               wr_nx = 1'b0;
               if (ba_rdy) gnt_nx = '0;
            end
         end
         WAIT: begin
            if (ba_rdy) gnt_nx = '0;
         end
         default: begin
            gnt_nx = '0;
            rd_nx  = 1'b0;
            wr_nx  = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt      <= '0;
         ba_rd    <= 1'b0;
         ba_wr    <= 1'b0;
         ba_addr  <= '0;
         ba_din   <= '0;
         ba_din_m <= MASK_NONE;
      end else begin
         gnt      <= gnt_nx;
         ba_rd    <= rd_nx;
         ba_wr    <= wr_nx;
         ba_addr  <= addr_nx;
         ba_din   <= din_nx;
         ba_din_m <= din_m_nx;
      end
   end

   // Board strobes reach the granted requester only; dropped when idle
   assign req_ack = gnt & {N{ba_ack}};
   assign req_dst = gnt & {N{ba_dst}};
   assign req_dok = gnt & {N{ba_dok}};
   assign req_rdy = gnt & {N{ba_rdy}};

endmodule
